mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of bytes in the internal byte store (a power of two, 16..65536).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the request address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1, meaning 1 = byte write and 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDR_W, meaning the start byte address.
REQ-009 The block SHALL have port req_len, input, 2, meaning the read length in bytes (1..3; 0 is treated as 1).
REQ-010 The block SHALL have port req_wdata, input, 8, meaning the write byte.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the initiator accepts the response.
REQ-013 The block SHALL have port rsp_data, output, 24, meaning the read bytes, with the first byte in [23:16], the second in [15:8] and the third in [7:0].
REQ-014 The block SHALL have port rsp_err, output, 1, meaning an out-of-range access (see Configuration).

Function
REQ-015 The block SHALL implement the states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where req_valid && req_ready; addr, len, we and wdata SHALL be latched at that edge.
REQ-017 Read: on acceptance the block SHALL go IDLE->READ, fetching one byte per cycle at addr, addr+1 and addr+2; after the len-th byte it SHALL go to RESP, so rsp_valid rises exactly len cycles after the acceptance edge.
REQ-018 Address increment SHALL wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000); the store index SHALL be the address modulo DEPTH.
REQ-019 Unread byte lanes of rsp_data SHALL be 0x00 (for example, len=1 gives rsp_data = {b0, 8'h00, 8'h00}).
REQ-020 Write: on acceptance the block SHALL go IDLE->WRITE; the byte SHALL be written at the next edge, followed by RESP with rsp_data = 0; rsp_valid rises 1 cycle after acceptance.
REQ-021 In RESP, rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready; the block SHALL return to IDLE on the edge where rsp_valid && rsp_ready.
REQ-022 No request SHALL be accepted in the same cycle as a response handshake; back-to-back throughput is one request per len+2 cycles (read) or 3 cycles (write).
REQ-023 Inputs other than rsp_ready SHALL be ignored outside IDLE.
REQ-024 In IDLE, rsp_valid SHALL be 0.
REQ-025 A read SHALL return data written by any earlier completed write (read-after-write coherence).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, and req_ready=1 once rst_n is high again.
REQ-027 A reset in mid-operation SHALL abandon the operation with no response; a write in WRITE state not yet clocked SHALL NOT occur.
REQ-028 The byte store contents SHALL NOT be cleared by reset.

Configuration
REQ-029 The macro MEM_RESP_BOUNDS_EN SHALL control bounds checking.
REQ-030 With MEM_RESP_BOUNDS_EN defined: any byte address >= DEPTH SHALL set rsp_err=1, return 0x00 for that lane, and suppress the write.
REQ-031 Without MEM_RESP_BOUNDS_EN: rsp_err SHALL be tied 0 and addresses SHALL alias modulo DEPTH.

Structure
REQ-032 A shared package mem_resp_pkg SHALL hold the state enum (IDLE/READ/WRITE/RESP), the 2-bit length type and the lane constants.
REQ-033 The byte store SHALL be one sub-module, mem_resp_ram: one synchronous write port and one synchronous read port, 8-bit.

Verification
REQ-034 Bench: write 0xC3@0x0010, 0x34@0x0011, 0x12@0x0012, then read len=3 @0x0010 -> rsp_data=0xC33412, with rsp_valid 3 cycles after acceptance.
REQ-035 Bench: read len=1 @0x0011 -> rsp_data=0x340000; len=0 -> identical result.
REQ-036 Bench: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 Bench: DEPTH=4096, write 0xAA@0x0FFF and 0xBB@0x0000, read len=2 @0x0FFF -> without the macro 0xAABB00; with the macro, read @0xFFFF -> rsp_err=1.
REQ-038 Bench: assert rst_n=0 during READ of a len=3 request -> no rsp_valid, req_ready=1 after release, and previously written data intact.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_responder block.
//   state_t  : responder FSM states (IDLE/READ/WRITE/RESP)
//   len_t    : 2-bit request length (0 means 1 byte)
//   LANE_*   : response byte-lane geometry; lane 0 is the first byte, in the MSBs
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [1:0] len_t;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 3;
  localparam int RSP_W     = LANE_W * NUM_LANES;

  // Length 0 is treated as a single-byte read.
  function automatic len_t eff_len(input len_t len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: DEPTH x 8 byte store, one synchronous write port and one
// synchronous (registered) read port. Addresses are reduced modulo DEPTH by
// keeping the low log2(DEPTH) bits. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write byte address (ADDR_W)
//   wdata : write byte
//   raddr : read byte address (ADDR_W)
//   rdata : byte at raddr, valid the cycle after raddr is presented
module mem_resp_ram #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] widx, ridx;

  assign widx = AW'(waddr);
  assign ridx = AW'(raddr);

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding byte memory responder.
// A read fetches len (1..3, 0 = 1) consecutive bytes, one per cycle, and
// returns them packed MSB-first in rsp_data; a write stores one byte and
// returns rsp_data = 0. The response is held until rsp_ready.
// Optional feature macro: MEM_RESP_BOUNDS_EN -- when defined, any byte address
// >= DEPTH flags rsp_err, reads 0x00 for that lane and suppresses the write;
// otherwise rsp_err is 0 and addresses alias modulo DEPTH.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_we               : 1 = byte write, 0 = read
//   req_addr, req_len    : start byte address, read length
//   req_wdata            : write byte
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_err    : read bytes (first in [23:16]), out-of-range flag
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_err
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;   // address of the byte being handled this cycle
  logic [ADDR_W-1:0] rd_addr;
  len_t              len_q;
  len_t              cnt;        // bytes already captured
  logic [7:0]        wdata_q;
  logic [7:0]        rd_byte;
  logic [7:0]        lane_byte;
  logic              ram_we;
  logic              cur_oob;

  assign req_ready = (state == IDLE);

`ifdef MEM_RESP_BOUNDS_EN
  logic err_q;
  assign cur_oob = (32'(cur_addr) >= 32'(DEPTH));
  assign rsp_err = err_q;
`else
  assign cur_oob = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // The RAM read is registered, so the address is presented one cycle ahead:
  // in IDLE the incoming request address (byte 0 lands in the first READ
  // cycle), in READ the byte after the one currently being captured.
  // Address arithmetic wraps at 2^ADDR_W.
  assign rd_addr   = (state == IDLE) ? req_addr : cur_addr + ADDR_W'(1);
  assign lane_byte = cur_oob ? 8'h00 : rd_byte;
  // Only driven from the WRITE state, so a reset before the write edge
  // drops the write.
  assign ram_we    = (state == WRITE) && !cur_oob;

  mem_resp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_addr),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (rd_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cur_addr  <= '0;
      len_q     <= 2'd1;
      cnt       <= 2'd0;
      wdata_q   <= 8'h00;
`ifdef MEM_RESP_BOUNDS_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr;
            len_q    <= eff_len(req_len);
            wdata_q  <= req_wdata;
            cnt      <= 2'd0;
            rsp_data <= '0;
`ifdef MEM_RESP_BOUNDS_EN
            err_q    <= 1'b0;
`endif
            state    <= req_we ? WRITE : READ;
          end
        end
        READ: begin
          case (cnt)
            2'd0:    rsp_data[23:16] <= lane_byte;
            2'd1:    rsp_data[15:8]  <= lane_byte;
            default: rsp_data[7:0]   <= lane_byte;
          endcase
`ifdef MEM_RESP_BOUNDS_EN
          if (cur_oob) err_q <= 1'b1;
`endif
          cur_addr <= cur_addr + ADDR_W'(1);
          cnt      <= cnt + 2'd1;
          if (cnt == len_q - 2'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        WRITE: begin
`ifdef MEM_RESP_BOUNDS_EN
          err_q     <= cur_oob;
`endif
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. A byte-array model
// predicts each response when the request is driven; predictions are queued
// and popped when the DUT presents its response. Build with or without
// MEM_RESP_BOUNDS_EN; the model follows the same macro.
module tb_mem_responder;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 16;

  typedef struct {
    logic [23:0] data;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_len = '0;
  logic [7:0]        req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [23:0]       rsp_data;
  logic              rsp_err;

  exp_t       exp_q[$];
  logic [7:0] mdl [DEPTH];
  int         n_tests = 0;
  int         n_fail  = 0;

  mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit oob(input logic [ADDR_W-1:0] a);
`ifdef MEM_RESP_BOUNDS_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Predict the response of one request and queue it.
  task automatic model(input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [1:0] len, input logic [7:0] wd);
    exp_t e;
    int   n;
    logic [ADDR_W-1:0] a;
    e.data = '0;
    e.err  = 1'b0;
    if (we) begin
      if (oob(addr)) e.err = 1'b1;
      else mdl[int'(addr) % DEPTH] = wd;
    end else begin
      n = (len == 2'd0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) begin
        a = addr + ADDR_W'(i);
        if (oob(a)) e.err = 1'b1;
        else e.data[23-8*i -: 8] = mdl[int'(a) % DEPTH];
      end
    end
    exp_q.push_back(e);
  endtask

  // One full transaction; hold = cycles rsp_ready stays low once rsp_valid rises.
  task automatic txn(input bit we, input logic [ADDR_W-1:0] addr,
                     input logic [1:0] len, input logic [7:0] wd, input int hold);
    int   lat, exp_lat;
    exp_t e;
    exp_lat = we ? 1 : ((len == 2'd0) ? 1 : int'(len));
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wd;
    model(we, addr, len, wd);
    @(posedge clk);
    #1;
    // Scramble request fields: the DUT must use its latched copy.
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_len = ~len; req_wdata = ~wd;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, e.data);
      chk("hold_ready", req_ready, 0);
      // A request presented while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 8'hFF;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", rsp_err, e.err);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_valid", rsp_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask

  // Start a request, then reset mid-flight (READ after one byte, or WRITE
  // before its write edge). No response is expected.
  task automatic abort_txn(input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [1:0] len, input logic [7:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!we) begin
      @(posedge clk);
      #1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_err", rsp_err, 0);
    rst_n = 1'b1;

    // Give the low addresses known contents.
    for (int a = 0; a < 64; a++) txn(1'b1, 16'(a), 2'd0, 8'($urandom_range(0, 255)), 0);

    // Three writes then a 3-byte read.
    txn(1'b1, 16'h0010, 2'd0, 8'hC3, 0);
    txn(1'b1, 16'h0011, 2'd0, 8'h34, 0);
    txn(1'b1, 16'h0012, 2'd0, 8'h12, 0);
    txn(1'b0, 16'h0010, 2'd3, 8'h00, 0);
    chk("direct_c33412", {mdl[16'h10], mdl[16'h11], mdl[16'h12]}, 24'hC33412);

    // Single-byte reads, len=1 and len=0.
    txn(1'b0, 16'h0011, 2'd1, 8'h00, 0);
    txn(1'b0, 16'h0011, 2'd0, 8'h00, 0);

    // Response back-pressure for 5 cycles.
    txn(1'b0, 16'h0010, 2'd2, 8'h00, 5);
    // The write offered during back-pressure must not have landed.
    txn(1'b0, 16'h0010, 2'd1, 8'h00, 0);

    // Wrap around the store and the address space.
    txn(1'b1, 16'h0FFF, 2'd0, 8'hAA, 0);
    txn(1'b1, 16'h0000, 2'd0, 8'hBB, 0);
    txn(1'b0, 16'h0FFF, 2'd2, 8'h00, 0);
    txn(1'b0, 16'hFFFF, 2'd3, 8'h00, 0);

    // Reset during READ and during WRITE; data must survive.
    abort_txn(1'b0, 16'h0010, 2'd3, 8'h00);
    abort_txn(1'b1, 16'h0010, 2'd0, 8'h55);
    txn(1'b0, 16'h0010, 2'd3, 8'h00, 0);

    // Write above DEPTH: aliases without bounds checking, errors with it.
    txn(1'b1, 16'h1010, 2'd0, 8'h77, 0);
    txn(1'b0, 16'h0010, 2'd1, 8'h00, 0);

    // Random mix over the initialised range.
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 61)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
          int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
